debounce_bank: RTL and testbench
================================

// Module: debounce_bank
//
// PURPOSE
//  Multi-channel synchronizer/debouncer for asynchronous board inputs (SW, BTN,
//  pad lines) entering the core_clock domain.
//  Generalises the single-input debouncer:
//   - channel width, settle delay and reset level are parametrised
//   - adds registered rise/fall event pulses
//   - optional hold-to-repeat pulses
//  Sits between the top-level pins and any consumer (power switch, joypad, debug step).
//
// PARAMETERS
//  CHANNELS       8       number of independent input channels (>=1)
//  DELAY          335000  stable cycles required before clean follows input (>=1; ~10 ms @ 33.5 MHz)
//  RESET_VAL      0       level of sync/candidate/clean registers in reset (applied to all channels)
//  REPEAT_DELAY   16750000  cycles from rise to first repeat pulse (~0.5 s; used only with macro; >=1)
//  REPEAT_PERIOD  3350000   cycles between later repeat pulses (~0.1 s; used only with macro; >=1)
//  CNT_W is a localparam, not a parameter: CNT_W = $clog2(DELAY+1).
//
// PORTS
//  core_clock  in   1         core clock; all logic on posedge
//  reset       in   1         synchronous, active-high
//  noisy       in   CHANNELS  raw asynchronous inputs
//  clean       out  CHANNELS  debounced levels
//  rise        out  CHANNELS  1-cycle pulse when clean[i] goes 0->1
//  fall        out  CHANNELS  1-cycle pulse when clean[i] goes 1->0
//  changed     out  1         |(rise|fall), same cycle as those pulses
//  repeat      out  CHANNELS  hold-repeat pulses; constant 0 without the macro
//
// BEHAVIOUR
//  Edge numbering: edge k is the first posedge that samples a new noisy level.
//
//  Per-channel pipeline:
//   - Two-flop synchronizer sync1 -> sync2. Reset value RESET_VAL.
//   - Candidate register cand and a CNT_W-bit counter cnt.
//   - Update rules, evaluated on each posedge, first matching rule wins:
//     1. reset: cand <= RESET_VAL, cnt <= 0, clean <= RESET_VAL, rise/fall/repeat <= 0.
//     2. sync2 != cand: cand <= sync2, cnt <= 0.
//     3. cnt == DELAY-1: clean <= cand. cnt holds (saturates); it never wraps.
//     4. otherwise: cnt <= cnt+1.
//
//  Latency:
//   - Level held from edge k: cand updates at edge k+2.
//   - clean updates at edge k+DELAY+2.
//   - rise/fall are registered in the same cycle as the clean update (same edge).
//   - Check with DELAY=1: clean updates at edge k+3.
//
//  Rejection of short or bouncing inputs:
//   - A level held at sync2 for fewer than DELAY+1 consecutive cycles never reaches clean.
//   - Any toggle restarts the count.
//   - Such a glitch produces no pulses.
//
//  Event outputs:
//   - rise[i] = clean_next & ~clean; fall[i] = ~clean_next & clean.
//   - Each is high for exactly one cycle.
//   - The two are never both high on the same channel.
//
//  Boundary conditions:
//   - Channels are fully independent. Simultaneous events on several channels set all
//     corresponding rise/fall bits in the same cycle; changed is high for that one cycle only.
//   - Reset mid-count aborts the pending transition. Nothing is emitted after reset deasserts
//     until a full new settle completes.
//   - RESET_VAL=1 with noisy=1 after reset: no rise pulse, because clean already equals 1.
//
// CONFIGURATION
//  Macro: DEBOUNCE_BANK_REPEAT_EN
//
//  Defined:
//   - Each channel gets a repeat counter rcnt. rcnt <= 0 on rise[i].
//   - While clean[i]==1, rcnt increments each cycle.
//   - repeat[i] pulses for 1 cycle REPEAT_DELAY cycles after the rise cycle.
//   - It then pulses every REPEAT_PERIOD cycles while clean[i] stays 1.
//   - fall[i] or reset stops repeats immediately; no pulse is emitted in the fall cycle.
//  Undefined:
//   - repeat is tied to 0 and no repeat counters are synthesised.
//   - The port list is unchanged.
//
// TESTING  (CHANNELS=4, DELAY=4, RESET_VAL=0; macro runs use REPEAT_DELAY=8, REPEAT_PERIOD=3)
//  1. Reset, noisy=4'h0, then noisy[0]=1 held.
//     -> clean=0, pulses=0 through edge k+5.
//     -> clean[0]=1 and rise[0]=1 after edge k+6; rise[0] low after edge k+7; changed mirrors rise[0].
//  2. noisy[1]=1 for 3 cycles, then 0.
//     -> clean[1] stays 0; rise, fall and changed never assert.
//  3. noisy[2] toggles every cycle for 10 cycles, then holds 1; last toggle sampled at edge m.
//     -> rise[2] asserts after edge m+6; exactly one pulse.
//  4. noisy[0] and noisy[3] rise in the same cycle.
//     -> rise=4'b1001 for one cycle; changed=1 for that one cycle only.
//     -> then both fall together -> fall=4'b1001 for one cycle.
//  5. noisy[1]=1; reset asserted at edge k+4 for one cycle, noisy still 1.
//     -> clean[1]=0 at and after reset.
//     -> rise[1] asserts DELAY+2 edges after the first post-reset sampling edge, not earlier.
//  6. Macro run: noisy[0] held 1 to past the third repeat pulse, then released; rise[0] in cycle r.
//     -> repeat[0] pulses at r+8, r+11, r+14.
//     -> no repeat pulse in or after the fall cycle.
//     Same stimulus without the macro: repeat==0 throughout.

Source files
------------

// File: rtl/debounce_bank.sv
// Multi-channel synchronizer/debouncer with registered rise/fall pulses.
// Define DEBOUNCE_BANK_REPEAT_EN to enable hold-to-repeat pulses.
module debounce_bank #(
  parameter int CHANNELS      = 8,
  parameter int DELAY         = 335000,
  parameter bit RESET_VAL     = 1'b0,
  parameter int REPEAT_DELAY  = 16750000,
  parameter int REPEAT_PERIOD = 3350000
) (
  input  logic                core_clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] noisy,
  output logic [CHANNELS-1:0] clean,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                changed,
  output logic [CHANNELS-1:0] repeat_pulse
);

  localparam int CNT_W = $clog2(DELAY + 1);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DELAY - 1);

`ifdef DEBOUNCE_BANK_REPEAT_EN
  localparam int RPT_MAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ?
    REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCNT_W = $clog2(RPT_MAX + 1);
  localparam logic [RCNT_W-1:0] RD_M1 =
    RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] RP_M1 =
    RCNT_W'(REPEAT_PERIOD - 1);
`endif

  if (CHANNELS < 1 || DELAY < 1 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)
  begin : g_bad_cfg
    $error("debounce_bank: bad parameters");
  end

  assign changed = |(rise | fall);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic             s1;
    logic             s2;
    logic             cand;
    logic             cl;
    logic             cl_nx;
    logic             rs;
    logic             fl;
    logic [CNT_W-1:0] cnt;

    // clean follows cand only once cand has been stable DELAY cycles
    always_comb begin
      cl_nx = cl;
      if (s2 == cand && cnt == CNT_MAX)
        cl_nx = cand;
    end

    always_ff @(posedge core_clock) begin
      if (reset) begin
        s1   <= RESET_VAL;
        s2   <= RESET_VAL;
        cand <= RESET_VAL;
        cnt  <= '0;
        cl   <= RESET_VAL;
        rs   <= 1'b0;
        fl   <= 1'b0;
      end else begin
        s1 <= noisy[i];
        s2 <= s1;
        if (s2 != cand) begin
          cand <= s2;
          cnt  <= '0;
        end else if (cnt != CNT_MAX) begin
          cnt <= cnt + 1'b1;
        end
        cl <= cl_nx;
        rs <= cl_nx & ~cl;
        fl <= ~cl_nx & cl;
      end
    end

    assign clean[i] = cl;
    assign rise[i]  = rs;
    assign fall[i]  = fl;

`ifdef DEBOUNCE_BANK_REPEAT_EN
    logic [RCNT_W-1:0] rcnt;
    logic [RCNT_W-1:0] lim;
    logic              fired;
    logic              rp;

    assign lim = fired ? RP_M1 : RD_M1;

    // rcnt counts cycles since the rise or the last repeat pulse
    always_ff @(posedge core_clock) begin
      if (reset) begin
        rcnt  <= '0;
        fired <= 1'b0;
        rp    <= 1'b0;
      end else if (!cl_nx || !cl) begin
        rcnt  <= '0;
        fired <= 1'b0;
        rp    <= 1'b0;
      end else if (rcnt == lim) begin
        rcnt  <= '0;
        fired <= 1'b1;
        rp    <= 1'b1;
      end else begin
        rcnt <= rcnt + 1'b1;
        rp   <= 1'b0;
      end
    end

    assign repeat_pulse[i] = rp;
`else
    assign repeat_pulse[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Randomized bench for debounce_bank against a sample-window reference model.
// Covers glitches, simultaneous edges, mid-count resets and repeat pulses.
module tb_debounce_bank;

  localparam int CH   = 4;
  localparam int DLY  = 4;
  localparam bit RV   = 1'b0;
  localparam int RD   = 8;
  localparam int RP   = 3;
  localparam int MAXE = 16384;

  logic          core_clock = 1'b0;
  logic          reset;
  logic [CH-1:0] noisy;
  logic [CH-1:0] clean;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
  logic          changed;
  logic [CH-1:0] repeat_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  bit hist [CH][MAXE];
  int t        = 0;
  int last_rst = -1;
  int rstart [CH];
  logic [CH-1:0] e_clean;
  logic [CH-1:0] e_rise;
  logic [CH-1:0] e_fall;
  logic [CH-1:0] e_rep;

  debounce_bank #(
    .CHANNELS      (CH),
    .DELAY         (DLY),
    .RESET_VAL     (RV),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .core_clock   (core_clock),
    .reset        (reset),
    .noisy        (noisy),
    .clean        (clean),
    .rise         (rise),
    .fall         (fall),
    .changed      (changed),
    .repeat_pulse (repeat_pulse)
  );

  always #5 core_clock = ~core_clock;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %h expected %h",
               tag, t, got, exp);
    end
  endtask

  // clean takes level v once the DLY+1 samples taken two or more
  // edges ago all equal v; samples at or before a reset count as RV
  task automatic model_step(input logic [CH-1:0] n,
                            input logic r);
    for (int c = 0; c < CH; c++)
      hist[c][t] = r ? RV : n[c];
    if (r) begin
      last_rst = t;
      e_clean  = {CH{RV}};
      e_rise   = '0;
      e_fall   = '0;
      e_rep    = '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        bit v0;
        bit s;
        bit same;
        bit old;
        bit nw;
        int age;
        same = 1'b1;
        v0   = RV;
        for (int j = t - DLY - 2; j <= t - 2; j++) begin
          if (j <= last_rst) s = RV;
          else s = hist[c][j];
          if (j == t - DLY - 2) v0 = s;
          else if (s != v0) same = 1'b0;
        end
        old = e_clean[c];
        nw  = same ? v0 : old;
        e_clean[c] = nw;
        e_rise[c]  = nw & ~old;
        e_fall[c]  = ~nw & old;
        if (e_rise[c]) rstart[c] = t;
        age = t - rstart[c];
        e_rep[c] = 1'b0;
`ifdef DEBOUNCE_BANK_REPEAT_EN
        if (nw && old)
          e_rep[c] = (age == RD) ||
                     (age > RD && (age - RD) % RP == 0);
`endif
      end
    end
    t++;
  endtask

  task automatic cycle(input logic [CH-1:0] n,
                       input logic r);
    noisy = n;
    reset = r;
    @(posedge core_clock);
    model_step(n, r);
    #1;
    check("clean",   32'(clean),        32'(e_clean));
    check("rise",    32'(rise),         32'(e_rise));
    check("fall",    32'(fall),         32'(e_fall));
    check("changed", 32'(changed),      32'(|(e_rise | e_fall)));
    check("repeat",  32'(repeat_pulse), 32'(e_rep));
  endtask

  initial begin
    logic [CH-1:0] cur;
    int            len;
    int            seg_mask;
    cur = '0;
    for (int c = 0; c < CH; c++) rstart[c] = 0;
    e_clean = '0;
    e_rise  = '0;
    e_fall  = '0;
    e_rep   = '0;
    noisy   = '0;
    reset   = 1'b1;
    @(negedge core_clock);
    repeat (3) cycle(cur, 1'b1);
    repeat (8) cycle(cur, 1'b0);
    for (int s = 0; s < 400 && t < MAXE - 64; s++) begin
      if ($urandom_range(0, 29) == 0) begin
        len = $urandom_range(1, 2);
        repeat (len) cycle(cur, 1'b1);
      end
      seg_mask = $urandom_range(1, (1 << CH) - 1);
      cur ^= CH'(seg_mask);
      if ($urandom_range(0, 2) == 0)
        len = $urandom_range(1, 4);
      else
        len = $urandom_range(5, 30);
      repeat (len) cycle(cur, 1'b0);
    end
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
